traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 SHALL have parameter GREEN_MAIN_T, default 20, main-road green duration in ticks.
REQ-002 SHALL have parameter GREEN_SIDE_T, default 10, side-road green duration in ticks.
REQ-003 SHALL have parameter YELLOW_T, default 3, yellow duration in ticks, both roads.
REQ-004 SHALL have parameter ALL_RED_T, default 2, all-red clearance duration in ticks.
REQ-005 SHALL have parameter WALK_T, default 8, pedestrian walk duration in ticks.
REQ-006 SHALL have port sys_clk, input, 1, single system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port tick, input, 1, one-cycle timebase pulse from the upstream clock divider.
REQ-009 SHALL have port ped_req, input, 1, pedestrian button; level, synchronous to sys_clk.
REQ-010 SHALL have port main_lamp, output, 3, main-road {red, yellow, green}, one-hot.
REQ-011 SHALL have port side_lamp, output, 3, side-road {red, yellow, green}, one-hot.
REQ-012 SHALL have port walk, output, 1, pedestrian walk lamp.
REQ-013 SHALL have port ped_ack, output, 1, one-cycle pulse acknowledging a latched request.
REQ-014 SHALL have port phase, output, 3, current state code, for debug and display.

Function
REQ-015 SHALL implement states MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5, PED_WALK=6.
REQ-016 SHALL sequence MAIN_GREEN -> MAIN_YELLOW -> ALL_RED_1 -> SIDE_GREEN -> SIDE_YELLOW -> ALL_RED_2 -> (PED_WALK if ped_pending, else MAIN_GREEN); PED_WALK -> MAIN_GREEN.
REQ-017 SHALL hold an 8-bit phase timer, loaded with the new state's duration on every state entry.
REQ-018 SHALL, on a cycle with tick=1, transition when timer==1; otherwise decrement the timer; no timer or state change when tick=0.
REQ-019 SHALL make each state last exactly its duration in ticks; legal durations are 1..255; 0 is illegal and unsupported.
REQ-020 SHALL decode lamps solely from the state register: green/yellow on the active road, red on the other; red on both roads in ALL_RED_1, ALL_RED_2 and PED_WALK; walk=1 only in PED_WALK.
REQ-021 SHALL set ped_pending when ped_req=1, ped_pending=0 and state is not PED_WALK; in that same cycle ped_ack SHALL pulse for exactly one cycle.
REQ-022 SHALL clear ped_pending on the transition into PED_WALK; ped_req in that cycle or during PED_WALK is ignored (no latch, no ack).
REQ-023 SHALL ignore a held ped_req while ped_pending=1 (no repeated ack).
REQ-024 SHALL drive phase equal to the state code.

Reset
REQ-025 SHALL, on reset=1, asynchronously force state ALL_RED_2, timer=ALL_RED_T, ped_pending=0.
REQ-026 SHALL output during and after reset: main_lamp=100, side_lamp=100, walk=0, ped_ack=0, phase=5.
REQ-027 SHALL abort any phase on reset mid-operation, with no partial lamp combinations; after release the first state is MAIN_GREEN after ALL_RED_T ticks.

Configuration
REQ-028 SHALL compile the pedestrian phase only when macro PED_CROSSING_EN is defined.
REQ-029 SHALL, with PED_CROSSING_EN defined, behave per REQ-015..REQ-023.
REQ-030 SHALL, without PED_CROSSING_EN, omit PED_WALK and ped_pending: ALL_RED_2 -> MAIN_GREEN always, walk tied 0, ped_ack tied 0, ped_req unused.

Verification (GREEN_MAIN_T=3, GREEN_SIDE_T=2, YELLOW_T=1, ALL_RED_T=1, WALK_T=2; PED_CROSSING_EN defined unless stated)
REQ-031 SHALL check: tick=1 every cycle, no ped_req, after reset release -> phase sequence 5,0,0,0,1,2,3,3,4,5,0 with matching one-hot lamps.
REQ-032 SHALL check: tick once every 4 cycles -> MAIN_GREEN lasts exactly 12 cycles; no state change on non-tick cycles.
REQ-033 SHALL check: ped_req held 5 cycles during SIDE_GREEN -> one ped_ack pulse; after ALL_RED_2 -> PED_WALK for 2 ticks with walk=1 and both reds, then MAIN_GREEN.
REQ-034 SHALL check: ped_req pulsed during PED_WALK -> no ack, no second walk phase.
REQ-035 SHALL check: reset asserted mid-SIDE_GREEN with ped_pending=1 -> immediate lamps 100/100, phase=5, pending cleared, next cycle goes to MAIN_GREEN with no walk.
REQ-036 SHALL check: PED_CROSSING_EN undefined, ped_req held high -> walk=0, ped_ack=0, phase never 6.

Source files
------------

// File: rtl/traffic_light_fsm.sv
// Traffic light controller: main/side road phases with all-red clearance, paced by an external tick.
// The pedestrian walk phase is built only when PED_CROSSING_EN is defined.
module traffic_light_fsm #(
   parameter int GREEN_MAIN_T = 20,
   parameter int GREEN_SIDE_T = 10,
   parameter int YELLOW_T     = 3,
   parameter int ALL_RED_T    = 2,
   parameter int WALK_T       = 8
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       ped_req,
   output logic [2:0] main_lamp,
   output logic [2:0] side_lamp,
   output logic       walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

`ifdef PED_CROSSING_EN
   typedef enum logic [2:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      ALL_RED_1   = 3'd2,
      SIDE_GREEN  = 3'd3,
      SIDE_YELLOW = 3'd4,
      ALL_RED_2   = 3'd5,
      PED_WALK    = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      MAIN_GREEN  = 3'd0,
      MAIN_YELLOW = 3'd1,
      ALL_RED_1   = 3'd2,
      SIDE_GREEN  = 3'd3,
      SIDE_YELLOW = 3'd4,
      ALL_RED_2   = 3'd5
   } state_t;
`endif

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   localparam logic [7:0] GREEN_MAIN_D = 8'(GREEN_MAIN_T);
   localparam logic [7:0] GREEN_SIDE_D = 8'(GREEN_SIDE_T);
   localparam logic [7:0] YELLOW_D     = 8'(YELLOW_T);
   localparam logic [7:0] ALL_RED_D    = 8'(ALL_RED_T);

   state_t     state_q, state_d, next_phase;
   logic [7:0] timer_q, timer_d, entry_dur;
   logic       ped_pending_q;

   always_comb begin
      next_phase = MAIN_GREEN;
      case (state_q)
         MAIN_GREEN:  next_phase = MAIN_YELLOW;
         MAIN_YELLOW: next_phase = ALL_RED_1;
         ALL_RED_1:   next_phase = SIDE_GREEN;
         SIDE_GREEN:  next_phase = SIDE_YELLOW;
         SIDE_YELLOW: next_phase = ALL_RED_2;
`ifdef PED_CROSSING_EN
         ALL_RED_2:   next_phase = ped_pending_q ? PED_WALK : MAIN_GREEN;
         PED_WALK:    next_phase = MAIN_GREEN;
`else
         ALL_RED_2:   next_phase = MAIN_GREEN;
`endif
         default:     next_phase = MAIN_GREEN;
      endcase
   end

   always_comb begin
      entry_dur = GREEN_MAIN_D;
      case (next_phase)
         MAIN_GREEN:  entry_dur = GREEN_MAIN_D;
         MAIN_YELLOW: entry_dur = YELLOW_D;
         ALL_RED_1:   entry_dur = ALL_RED_D;
         SIDE_GREEN:  entry_dur = GREEN_SIDE_D;
         SIDE_YELLOW: entry_dur = YELLOW_D;
         ALL_RED_2:   entry_dur = ALL_RED_D;
`ifdef PED_CROSSING_EN
         PED_WALK:    entry_dur = 8'(WALK_T);
`endif
         default:     entry_dur = GREEN_MAIN_D;
      endcase
   end

   // The timer counts down once per tick; reaching 1 on a tick ends the phase,
   // so a phase of duration N spans exactly N ticks.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (tick) begin
         if (timer_q == 8'd1) begin
            state_d = next_phase;
            timer_d = entry_dur;
         end else begin
            timer_d = timer_q - 8'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         state_q <= ALL_RED_2;
         timer_q <= ALL_RED_D;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

`ifdef PED_CROSSING_EN
   logic ped_set, ped_pending_d;

   // A request is latched (and acknowledged) only once; it is consumed on entry to the walk phase.
   always_comb begin
      ped_set       = ped_req && !ped_pending_q && (state_q != PED_WALK) && !reset;
      ped_pending_d = ped_pending_q;
      if ((state_d == PED_WALK) && (state_q != PED_WALK)) begin
         ped_pending_d = 1'b0;
      end else if (ped_set) begin
         ped_pending_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         ped_pending_q <= 1'b0;
      end else begin
         ped_pending_q <= ped_pending_d;
      end
   end

   assign ped_ack = ped_set;
`else
   logic unused_ped;

   assign ped_pending_q = 1'b0;
   assign ped_ack       = 1'b0;
   assign unused_ped    = ped_req ^ (WALK_T != 0);
`endif

   always_comb begin
      main_lamp = LAMP_RED;
      side_lamp = LAMP_RED;
      walk      = 1'b0;
      case (state_q)
         MAIN_GREEN:  main_lamp = LAMP_GREEN;
         MAIN_YELLOW: main_lamp = LAMP_YELLOW;
         SIDE_GREEN:  side_lamp = LAMP_GREEN;
         SIDE_YELLOW: side_lamp = LAMP_YELLOW;
`ifdef PED_CROSSING_EN
         PED_WALK:    walk = 1'b1;
`endif
         default: begin
            main_lamp = LAMP_RED;
            side_lamp = LAMP_RED;
         end
      endcase
   end

   assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with short phase durations; pedestrian
// scenarios run only when PED_CROSSING_EN is defined for the build.
module tb_traffic_light_fsm;

`ifdef PED_CROSSING_EN
   localparam logic PED_EN = 1'b1;
`else
   localparam logic PED_EN = 1'b0;
`endif

   logic       sys_clk;
   logic       reset;
   logic       tick;
   logic       ped_req;
   logic [2:0] main_lamp;
   logic [2:0] side_lamp;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   int n_checks;
   int n_fail;
   logic [2:0] exp_q[$];

   traffic_light_fsm #(
      .GREEN_MAIN_T(3),
      .GREEN_SIDE_T(2),
      .YELLOW_T    (1),
      .ALL_RED_T   (1),
      .WALK_T      (2)
   ) dut (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .tick     (tick),
      .ped_req  (ped_req),
      .main_lamp(main_lamp),
      .side_lamp(side_lamp),
      .walk     (walk),
      .ped_ack  (ped_ack),
      .phase    (phase)
   );

   // clock / reset
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_main(input logic [2:0] p);
      case (p)
         3'd0:    return 3'b001;
         3'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_side(input logic [2:0] p);
      case (p)
         3'd3:    return 3'b001;
         3'd4:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   task automatic check_lamps(input string tag, input logic [2:0] p);
      check({tag, "_main"}, 32'(main_lamp), 32'(exp_main(p)));
      check({tag, "_side"}, 32'(side_lamp), 32'(exp_side(p)));
      check({tag, "_walk"}, 32'(walk), 32'(p == 3'd6));
   endtask

   // driver tasks
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic apply_reset();
      reset   = 1'b1;
      tick    = 1'b0;
      ped_req = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain_exp(input string tag);
      logic [2:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(tag, 32'(phase), 32'(e));
         check_lamps(tag, e);
         step();
      end
   endtask

   initial begin
      logic [2:0] seq_run [11] = '{3'd5, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd5, 3'd0};
      int cnt_main, bad_change, acks, walks, p6;
      logic [2:0] prev;
      logic tick_was;

      n_checks = 0;
      n_fail   = 0;

      // Reset state, with a request and tick present during reset
      reset   = 1'b1;
      tick    = 1'b1;
      ped_req = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      check("rst_phase", 32'(phase), 32'd5);
      check_lamps("rst", 3'd5);
      check("rst_ack", 32'(ped_ack), 32'd0);
      ped_req = 1'b0;

      // Free-running tick, no requests: full cycle back to MAIN_GREEN
      apply_reset();
      tick = 1'b1;
      foreach (seq_run[i]) exp_q.push_back(seq_run[i]);
      drain_exp("seq");

      // Tick every 4th cycle: MAIN_GREEN spans 12 cycles, no change off-tick
      apply_reset();
      cnt_main   = 0;
      bad_change = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick     = (cyc % 4 == 0);
         tick_was = tick;
         prev     = phase;
         step();
         if (phase != prev && !tick_was) bad_change++;
         if (phase == 3'd0) cnt_main++;
      end
      check("slow_main_cycles", cnt_main, 32'd12);
      check("slow_offtick_changes", bad_change, 32'd0);
      check("slow_end_phase", 32'(phase), 32'd2);

`ifdef PED_CROSSING_EN
      // Held request during SIDE_GREEN: one ack, then a 2-tick walk phase
      apply_reset();
      tick = 1'b1;
      repeat (6) step();
      check("ped_start_phase", 32'(phase), 32'd3);
      acks = 0;
      exp_q = '{3'd3, 3'd3, 3'd4, 3'd5, 3'd6};
      for (int i = 0; i < 5; i++) begin
         ped_req = 1'b1;
         #1;
         if (ped_ack) acks++;
         check("ped_seq", 32'(phase), 32'(exp_q.pop_front()));
         step();
      end
      ped_req = 1'b0;
      check("ped_ack_count", acks, 32'd1);
      check("walk_phase", 32'(phase), 32'd6);
      check_lamps("walk", 3'd6);

      // Request during PED_WALK is ignored
      ped_req = 1'b1;
      #1;
      check("walk_req_ack", 32'(ped_ack), 32'd0);
      step();
      ped_req = 1'b0;
      check("after_walk_phase", 32'(phase), 32'd0);
      check_lamps("after_walk", 3'd0);
      p6 = 0;
      repeat (12) begin
         step();
         if (phase == 3'd6) p6++;
      end
      check("no_second_walk", p6, 32'd0);
`endif

      // Reset mid-SIDE_GREEN with a request latched
      apply_reset();
      tick = 1'b1;
      repeat (6) step();
      check("mid_phase", 32'(phase), 32'd3);
      ped_req = 1'b1;
      #1;
      check("mid_ack", 32'(ped_ack), 32'(PED_EN));
      step();
      ped_req = 1'b0;
      check("mid_phase2", 32'(phase), 32'd3);
      reset = 1'b1;
      #1;
      check("mid_rst_phase", 32'(phase), 32'd5);
      check_lamps("mid_rst", 3'd5);
      check("mid_rst_ack", 32'(ped_ack), 32'd0);
      reset = 1'b0;
      step();
      check("mid_first_phase", 32'(phase), 32'd0);
      walks = 0;
      p6    = 0;
      repeat (12) begin
         step();
         if (walk) walks++;
         if (phase == 3'd6) p6++;
      end
      check("mid_no_walk", walks, 32'd0);
      check("mid_no_ped_phase", p6, 32'd0);

`ifndef PED_CROSSING_EN
      // Without the pedestrian feature a held request has no effect
      apply_reset();
      tick    = 1'b1;
      ped_req = 1'b1;
      acks    = 0;
      walks   = 0;
      p6      = 0;
      repeat (20) begin
         #1;
         if (ped_ack) acks++;
         if (walk) walks++;
         if (phase == 3'd6) p6++;
         step();
      end
      ped_req = 1'b0;
      check("noped_ack", acks, 32'd0);
      check("noped_walk", walks, 32'd0);
      check("noped_phase6", p6, 32'd0);
`endif

      // final report
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
